// File: rtl/siphash_pkg.sv
// Shared constants and types for the SipHash controller and its round datapath.
package siphash_pkg;

    localparam logic [63:0] IV0       = 64'h736f6d6570736575;
    localparam logic [63:0] IV1       = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2       = 64'h6c7967656e657261;
    localparam logic [63:0] IV3       = 64'h7465646279746573;
    localparam logic [63:0] FINAL_XOR = 64'hff;

    localparam int unsigned DEFAULT_C_ROUNDS = 2;
    localparam int unsigned DEFAULT_D_ROUNDS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitMsg,
        StComp,
        StFinal,
        StDone
    } state_e;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned r);
        return (x << r) | (x >> (64 - r));
    endfunction

endpackage

// File: rtl/round.sv
// One registered SipRound: outputs reflect the inputs sampled at the previous edge.
module round
    import siphash_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] iv0,
    input  logic [63:0] iv1,
    input  logic [63:0] iv2,
    input  logic [63:0] iv3,
    output logic [63:0] ov0,
    output logic [63:0] ov1,
    output logic [63:0] ov2,
    output logic [63:0] ov3
);

    logic [63:0] s0a, s0b, s0c, s1a, s1b, s2a, s2b, s2c, s3a, s3b;

    always_comb begin
        s0a = iv0 + iv1;
        s1a = rotl64(iv1, 13) ^ s0a;
        s0b = rotl64(s0a, 32);
        s2a = iv2 + iv3;
        s3a = rotl64(iv3, 16) ^ s2a;
        s0c = s0b + s3a;
        s3b = rotl64(s3a, 21) ^ s0c;
        s2b = s2a + s1a;
        s1b = rotl64(s1a, 17) ^ s2b;
        s2c = rotl64(s2b, 32);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov0 <= '0;
            ov1 <= '0;
            ov2 <= '0;
            ov3 <= '0;
        end else begin
            ov0 <= s0c;
            ov1 <= s1b;
            ov2 <= s2c;
            ov3 <= s3b;
        end
    end

endmodule

// File: rtl/siphash_ctrl.sv
// SipHash-C-D sequencer: loads the key, absorbs padded words and finalizes using one
// registered round instance iterated back-to-back.
module siphash_ctrl
    import siphash_pkg::*;
#(
    parameter int unsigned C_ROUNDS = DEFAULT_C_ROUNDS,
    parameter int unsigned D_ROUNDS = DEFAULT_D_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic         msg_last,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [63:0]  hash
);

    localparam int unsigned MaxRounds = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
    localparam int unsigned CntW      = $clog2(MaxRounds + 1);

    state_e          state_q, state_d;
    logic [63:0]     v0_q, v1_q, v2_q, v3_q, v0_d, v1_d, v2_d, v3_d;
    logic [63:0]     m_q, m_d, hash_q, hash_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     iv0, iv1, iv2, iv3, ov0, ov1, ov2, ov3;

    round u_round (
        .clk   (clk),
        .rst_n (rst_n),
        .iv0   (iv0),
        .iv1   (iv1),
        .iv2   (iv2),
        .iv3   (iv3),
        .ov0   (ov0),
        .ov1   (ov1),
        .ov2   (ov2),
        .ov3   (ov3)
    );

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        m_d     = m_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hash_d  = hash_q;
        // Round inputs idle on the current state vector unless a round is being issued.
        iv0     = v0_q;
        iv1     = v1_q;
        iv2     = v2_q;
        iv3     = v3_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    v0_d    = key[63:0]   ^ IV0;
                    v1_d    = key[127:64] ^ IV1;
                    v2_d    = key[63:0]   ^ IV2;
                    v3_d    = key[127:64] ^ IV3;
                    state_d = StWaitMsg;
                end
            end
            StWaitMsg: begin
                if (msg_valid) begin
                    iv3     = v3_q ^ msg_data;
                    m_d     = msg_data;
                    last_d  = msg_last;
                    cnt_d   = CntW'(1);
                    state_d = StComp;
                end
            end
            StComp: begin
                if (cnt_q < CntW'(C_ROUNDS)) begin
                    {iv0, iv1, iv2, iv3} = {ov0, ov1, ov2, ov3};
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    v0_d    = ov0 ^ m_q;
                    v1_d    = ov1;
                    v2_d    = ov2;
                    v3_d    = ov3;
                    cnt_d   = '0;
                    state_d = last_q ? StFinal : StWaitMsg;
                end
            end
            StFinal: begin
                // cnt 0 issues the first finalization round with the v2 tweak.
                if (cnt_q == '0) begin
                    iv2   = v2_q ^ FINAL_XOR;
                    cnt_d = CntW'(1);
                end else if (cnt_q < CntW'(D_ROUNDS)) begin
                    {iv0, iv1, iv2, iv3} = {ov0, ov1, ov2, ov3};
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    hash_d  = ov0 ^ ov1 ^ ov2 ^ ov3;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (hash_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
            m_q     <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            m_q     <= m_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            hash_q  <= hash_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign msg_ready  = (state_q == StWaitMsg);
    assign hash_valid = (state_q == StDone);
    assign hash       = hash_q;

endmodule

// File: tb/tb_siphash_ctrl.sv
// Self-checking bench for siphash_ctrl against a word-level SipHash-2-4 software model.
module tb_siphash_ctrl;

    localparam int C = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         msg_valid;
    logic         msg_ready;
    logic [63:0]  msg_data;
    logic         msg_last;
    logic         hash_valid;
    logic         hash_ready;
    logic [63:0]  hash;

    siphash_ctrl #(
        .C_ROUNDS (C),
        .D_ROUNDS (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_data   (msg_data),
        .msg_last   (msg_last),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash       (hash)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] msg_w[8];
    int          msg_n;
    int          last_gap;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [3:0][63:0] sipround(input logic [3:0][63:0] v);
        v[0] += v[1]; v[1] = rotl(v[1], 13); v[1] ^= v[0]; v[0] = rotl(v[0], 32);
        v[2] += v[3]; v[3] = rotl(v[3], 16); v[3] ^= v[2];
        v[0] += v[3]; v[3] = rotl(v[3], 21); v[3] ^= v[0];
        v[2] += v[1]; v[1] = rotl(v[1], 17); v[1] ^= v[2]; v[2] = rotl(v[2], 32);
        return v;
    endfunction

    function automatic logic [63:0] model(input logic [127:0] k, input int n);
        logic [3:0][63:0] v;
        v[0] = k[63:0]   ^ 64'h736f6d6570736575;
        v[1] = k[127:64] ^ 64'h646f72616e646f6d;
        v[2] = k[63:0]   ^ 64'h6c7967656e657261;
        v[3] = k[127:64] ^ 64'h7465646279746573;
        for (int i = 0; i < n; i++) begin
            v[3] ^= msg_w[i];
            for (int r = 0; r < C; r++) v = sipround(v);
            v[0] ^= msg_w[i];
        end
        v[2] ^= 64'hff;
        for (int r = 0; r < D; r++) v = sipround(v);
        return v[0] ^ v[1] ^ v[2] ^ v[3];
    endfunction

    task automatic run_msg(input logic [127:0] k, input bit stalls, input int hold,
                           output logic [63:0] got, output int lat);
        int guard;
        int t_prev;
        start = 1'b1;
        key   = k;
        step();
        start = 1'b0;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        t_prev   = -1;
        last_gap = 0;
        for (int i = 0; i < msg_n; i++) begin
            if (stalls) repeat ($urandom_range(0, 3)) step();
            msg_valid = 1'b1;
            msg_data  = msg_w[i];
            msg_last  = (i == msg_n - 1);
            guard = 0;
            while (!msg_ready && guard < 50) begin
                step();
                guard++;
            end
            check("msg_ready_seen", {63'b0, msg_ready}, 64'd1);
            step();
            if (t_prev >= 0) last_gap = cyc - t_prev;
            t_prev    = cyc;
            // Next word stays offered while the block computes; it must not be taken early.
            msg_valid = stalls ? 1'b0 : (i < msg_n - 1);
            msg_data  = (i < msg_n - 1) ? msg_w[i+1] : 64'h0;
            msg_last  = 1'b0;
        end
        msg_valid = 1'b0;
        lat = 1;
        while (!hash_valid && lat < 100) begin
            step();
            lat++;
        end
        check("hash_valid_seen", {63'b0, hash_valid}, 64'd1);
        got = hash;
        for (int h = 0; h < hold; h++) begin
            start = $urandom_range(0, 1);
            key   = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("hold_valid", {63'b0, hash_valid}, 64'd1);
            check("hold_hash", hash, got);
        end
        hash_ready = 1'b1;
        start      = 1'b1;
        step();
        hash_ready = 1'b0;
        start      = 1'b0;
        check("valid_drop", {63'b0, hash_valid}, 64'd0);
        check("idle_after_done", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [127:0] kv;
        logic [127:0] kr;
        logic [63:0]  got;
        int           lat;

        rst_n = 1'b0; start = 1'b0; key = '0; msg_valid = 1'b0; msg_data = '0;
        msg_last = 1'b0; hash_ready = 1'b0;
        step();
        step();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_ready", {63'b0, msg_ready}, 64'd0);
        check("rst_valid", {63'b0, hash_valid}, 64'd0);
        check("rst_hash", hash, 64'd0);
        rst_n = 1'b1;
        step();

        kv = 128'h0f0e0d0c0b0a09080706050403020100;
        msg_n = 1; msg_w[0] = 64'h0;
        run_msg(kv, 1'b0, 0, got, lat);
        check("vec1_hash", got, 64'h726fdb47dd0e0e31);
        check("vec1_model", got, model(kv, msg_n));
        check("vec1_latency", 64'(lat), 64'(C + D + 2));

        msg_n = 2; msg_w[0] = 64'h0706050403020100; msg_w[1] = 64'h0800000000000000;
        run_msg(kv, 1'b0, 0, got, lat);
        check("vec2_hash", got, 64'h93f5f5799a932462);
        check("vec2_word_gap", 64'(last_gap), 64'(C + 1));
        check("vec2_latency", 64'(lat), 64'(C + D + 2));

        msg_n = 1; msg_w[0] = 64'h0;
        run_msg(kv, 1'b0, 10, got, lat);
        check("hold_run_hash", got, 64'h726fdb47dd0e0e31);

        // Reset one cycle into compression, then the same vector must still hash correctly.
        start = 1'b1; key = kv;
        step();
        start = 1'b0; msg_valid = 1'b1; msg_data = 64'h0; msg_last = 1'b1;
        step();
        msg_valid = 1'b0; msg_last = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_ready", {63'b0, msg_ready}, 64'd0);
        check("midrst_valid", {63'b0, hash_valid}, 64'd0);
        check("midrst_hash", hash, 64'd0);
        run_msg(kv, 1'b0, 0, got, lat);
        check("rerun_hash", got, 64'h726fdb47dd0e0e31);

        for (int r = 0; r < 6; r++) begin
            msg_n = (r == 0) ? 3 : int'($urandom_range(1, 4));
            for (int i = 0; i < msg_n; i++) msg_w[i] = {$urandom, $urandom};
            kr = {$urandom, $urandom, $urandom, $urandom};
            run_msg(kr, 1'b1, 0, got, lat);
            check("rand_hash", got, model(kr, msg_n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
